seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
//   Receive side of the team's 7-segment digit encoding: samples a time-multiplexed
//   segment bus {a,b,c,d,e,f,g} plus one-hot digit select, and per digit
//   debounces (STABLE_CNT identical samples) and decodes the pattern back to BCD.
//   Sits between a scanned display bus (or display-driver loopback) and BCD logic.
// PARAMETERS
//   DIGITS      4   number of multiplexed digits (1..8)
//   STABLE_CNT  3   consecutive identical samples required to commit a digit (1..15)
// PORTS
//   clk          in   1          rising-edge clock
//   rst_n        in   1          asynchronous, active-low reset
//   seg_in       in   7          segment levels, bit6=a .. bit0=g, active-high
//   dig_sel      in   DIGITS     one-hot digit select qualifying seg_in
//   sample_en    in   1          seg_in/dig_sel valid this cycle
//   bcd_out      out  4*DIGITS   committed BCD, digit i at [4i+3:4i]
//   digit_valid  out  DIGITS     digit i holds a committed legal code 0..9
//   seg_err      out  DIGITS     digit i committed an illegal (non-blank) pattern
//   upd          out  1          1-cycle pulse: some digit's committed state changed
//   sel_err      out  1          1-cycle pulse: sample_en with dig_sel not one-hot
// BEHAVIOUR
//   Reset (async, rst_n=0): bcd_out=0, digit_valid=0, seg_err=0, upd=0, sel_err=0;
//     candidates and counters cleared; in-flight pipeline sample discarded.
//   Decode table (exact match only): 1111110=0 0110000=1 1101101=2 1111001=3
//     0110011=4 1011011=5 1011111=6 1110000=7 1111111=8 1111011=9; 0000000=BLANK;
//     all other patterns=ILLEGAL.
//   Pipeline: stage1 registers seg_in, dig_sel, sample_en and decodes; stage2 updates
//     tracking and outputs. Sample at edge k -> outputs/upd/sel_err change at edge k+1.
//   dig_sel check: sample_en=1 with dig_sel zero or multi-hot -> sel_err pulses, sample
//     dropped, no tracking state changes. sample_en=0 -> nothing happens.
//   Per-digit FSM (cand[6:0], cnt[3:0]):
//     IDLE  : after reset. Sample -> cand=seg_in, cnt=1 -> TRACK (commit now if STABLE_CNT=1).
//     TRACK : sample==cand -> cnt+1; cnt reaching STABLE_CNT -> commit -> LOCKED.
//             sample!=cand -> cand=sample, cnt=1 (stay TRACK).
//     LOCKED: sample==cand -> hold, cnt saturates, no recommit.
//             sample!=cand -> cand=sample, cnt=1 -> TRACK; committed outputs held.
//   Commit: legal  -> bcd=code, digit_valid=1, seg_err=0.
//           BLANK  -> bcd=0, digit_valid=0, seg_err=0.
//           ILLEGAL-> bcd held, digit_valid=0, seg_err=1.
//   upd pulses only if {bcd,digit_valid,seg_err} of the digit actually differs; at most
//     one sample per cycle so at most one digit commits per cycle.
//   Unselected digits untouched. No wrap-around: cnt saturates at STABLE_CNT.
// TESTING
//   T1 reset; digit0 seg_in=1111001 x3 -> edge after 3rd: bcd_out[3:0]=3,
//      digit_valid[0]=1, upd one cycle; 4th identical sample -> no upd.
//   T2 digit1: 0110000 x2, then 1111111 x3 -> no commit after the 2; then bcd[7:4]=8,
//      valid[1]=1, single upd.
//   T3 after T1, digit0 1000001 x3 -> seg_err[0]=1, digit_valid[0]=0, bcd[3:0] stays 3.
//   T4 sample_en=1, dig_sel=0011 then 0000 -> sel_err pulses each, outputs/state unchanged.
//   T5 all ten legal patterns x3 on each digit, then 0000000 x3 -> correct BCD 0..9;
//      blank gives valid=0, err=0, bcd=0.
//   T6 rst_n low mid-count (2 of 3 samples) -> outputs 0 immediately; after release one
//      more sample does not commit (cnt restarts at 1).

Source files
------------

// File: rtl/seg7_scan_if.sv
// Scanned 7-segment receive bus: multiplexed segment/select samples in,
// debounced per-digit BCD and status out.
interface seg7_scan_if #(
    parameter int DIGITS = 4
);
    logic [6:0]          seg_in;
    logic [DIGITS-1:0]   dig_sel;
    logic                sample_en;
    logic [4*DIGITS-1:0] bcd_out;
    logic [DIGITS-1:0]   digit_valid;
    logic [DIGITS-1:0]   seg_err;
    logic                upd;
    logic                sel_err;

    modport master (
        output seg_in, dig_sel, sample_en,
        input  bcd_out, digit_valid, seg_err, upd, sel_err
    );

    modport slave (
        input  seg_in, dig_sel, sample_en,
        output bcd_out, digit_valid, seg_err, upd, sel_err
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Debounces a time-multiplexed 7-segment bus per digit and decodes each
// stable pattern back to BCD. Two-stage pipeline: decode, then track/commit.
module seg7_scan_decoder #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CNT = 3
) (
    input logic         clk,
    input logic         rst_n,
    seg7_scan_if.slave  bus
);
    typedef enum logic [1:0] {KIND_LEGAL, KIND_BLANK, KIND_ILLEGAL} kind_t;
    typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_LOCKED} state_t;

    localparam logic [3:0] STABLE = 4'(STABLE_CNT);

    logic [3:0] dec_code;
    kind_t      dec_kind;

    always_comb begin
        dec_code = 4'd0;
        dec_kind = KIND_LEGAL;
        case (bus.seg_in)
            7'b1111110: dec_code = 4'd0;
            7'b0110000: dec_code = 4'd1;
            7'b1101101: dec_code = 4'd2;
            7'b1111001: dec_code = 4'd3;
            7'b0110011: dec_code = 4'd4;
            7'b1011011: dec_code = 4'd5;
            7'b1011111: dec_code = 4'd6;
            7'b1110000: dec_code = 4'd7;
            7'b1111111: dec_code = 4'd8;
            7'b1111011: dec_code = 4'd9;
            7'b0000000: dec_kind = KIND_BLANK;
            default:    dec_kind = KIND_ILLEGAL;
        endcase
    end

    logic [6:0]        s1_seg_reg;
    logic [DIGITS-1:0] s1_sel_reg;
    logic              s1_en_reg;
    logic [3:0]        s1_code_reg;
    kind_t             s1_kind_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_seg_reg  <= '0;
            s1_sel_reg  <= '0;
            s1_en_reg   <= 1'b0;
            s1_code_reg <= '0;
            s1_kind_reg <= KIND_BLANK;
        end else begin
            s1_seg_reg  <= bus.seg_in;
            s1_sel_reg  <= bus.dig_sel;
            s1_en_reg   <= bus.sample_en;
            s1_code_reg <= dec_code;
            s1_kind_reg <= dec_kind;
        end
    end

    // Exactly one select bit set: non-zero and clearing the lowest set bit leaves zero.
    logic sel_ok;
    logic accept;
    assign sel_ok = (s1_sel_reg != '0) && ((s1_sel_reg & (s1_sel_reg - DIGITS'(1))) == '0);
    assign accept = s1_en_reg && sel_ok;

    logic [DIGITS-1:0]   digit_chg;
    logic [4*DIGITS-1:0] bcd_vec;
    logic [DIGITS-1:0]   valid_vec;
    logic [DIGITS-1:0]   err_vec;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            state_t     state_reg, state_next;
            logic [6:0] cand_reg, cand_next;
            logic [3:0] cnt_reg, cnt_next;
            logic [3:0] bcd_reg, bcd_next;
            logic       valid_reg, valid_next;
            logic       err_reg, err_next;
            logic       commit;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= ST_IDLE;
                    cand_reg  <= '0;
                    cnt_reg   <= '0;
                    bcd_reg   <= '0;
                    valid_reg <= 1'b0;
                    err_reg   <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cand_reg  <= cand_next;
                    cnt_reg   <= cnt_next;
                    bcd_reg   <= bcd_next;
                    valid_reg <= valid_next;
                    err_reg   <= err_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                cand_next  = cand_reg;
                cnt_next   = cnt_reg;
                bcd_next   = bcd_reg;
                valid_next = valid_reg;
                err_next   = err_reg;
                commit     = 1'b0;
                if (accept && s1_sel_reg[gi]) begin
                    if (state_reg != ST_IDLE && s1_seg_reg == cand_reg) begin
                        if (state_reg == ST_TRACK) begin
                            cnt_next = cnt_reg + 4'd1;
                            if (cnt_next >= STABLE) begin
                                commit     = 1'b1;
                                state_next = ST_LOCKED;
                            end
                        end else begin
                            cnt_next = STABLE;
                        end
                    end else begin
                        // New candidate; committed outputs stay until it proves stable.
                        cand_next = s1_seg_reg;
                        cnt_next  = 4'd1;
                        if (STABLE == 4'd1) begin
                            commit     = 1'b1;
                            state_next = ST_LOCKED;
                        end else begin
                            state_next = ST_TRACK;
                        end
                    end
                    if (commit) begin
                        case (s1_kind_reg)
                            KIND_LEGAL: begin
                                bcd_next   = s1_code_reg;
                                valid_next = 1'b1;
                                err_next   = 1'b0;
                            end
                            KIND_BLANK: begin
                                bcd_next   = 4'd0;
                                valid_next = 1'b0;
                                err_next   = 1'b0;
                            end
                            default: begin
                                valid_next = 1'b0;
                                err_next   = 1'b1;
                            end
                        endcase
                    end
                end
            end

            assign digit_chg[gi]        = {bcd_next, valid_next, err_next} != {bcd_reg, valid_reg, err_reg};
            assign bcd_vec[4*gi +: 4]   = bcd_reg;
            assign valid_vec[gi]        = valid_reg;
            assign err_vec[gi]          = err_reg;
        end
    endgenerate

    logic upd_reg;
    logic sel_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_reg     <= 1'b0;
            sel_err_reg <= 1'b0;
        end else begin
            upd_reg     <= |digit_chg;
            sel_err_reg <= s1_en_reg && !sel_ok;
        end
    end

    assign bus.bcd_out     = bcd_vec;
    assign bus.digit_valid = valid_vec;
    assign bus.seg_err     = err_vec;
    assign bus.upd         = upd_reg;
    assign bus.sel_err     = sel_err_reg;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: hand-computed vectors plus
// multi-cycle sequences for debounce, select errors and reset.
module tb_seg7_scan_decoder;
    localparam int DIGITS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CNT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [6:0] seg;
        logic [3:0] bcd;
        logic       valid;
        logic       err;
    } vec_t;

    vec_t tbl[12];

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [15:0] m_bcd;
    logic [3:0]  m_val;
    logic [3:0]  m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_state(input string name, input logic exp_upd, input logic exp_sel);
        chk({name, " bcd_out"},     32'(bus.bcd_out),     32'(m_bcd));
        chk({name, " digit_valid"}, 32'(bus.digit_valid), 32'(m_val));
        chk({name, " seg_err"},     32'(bus.seg_err),     32'(m_err));
        chk({name, " upd"},         32'(bus.upd),         32'(exp_upd));
        chk({name, " sel_err"},     32'(bus.sel_err),     32'(exp_sel));
    endtask

    // One sample, then one idle cycle so its stage-2 effect is visible on return.
    task automatic send(input logic [6:0] seg, input logic [3:0] sel);
        bus.seg_in    = seg;
        bus.dig_sel   = sel;
        bus.sample_en = 1'b1;
        @(posedge clk); #1;
        bus.sample_en = 1'b0;
        bus.dig_sel   = 4'b0000;
        @(posedge clk); #1;
        $display("sample seg=%b sel=%b -> bcd_out=%h valid=%b err=%b upd=%b sel_err=%b",
                 seg, sel, bus.bcd_out, bus.digit_valid, bus.seg_err, bus.upd, bus.sel_err);
    endtask

    task automatic mcommit(input int d, input logic [3:0] bcd, input logic v, input logic e,
                           output logic changed);
        logic [3:0] ob;
        logic       ov, oe;
        ob = m_bcd[4*d +: 4];
        ov = m_val[d];
        oe = m_err[d];
        if (e) begin
            m_val[d] = 1'b0;
            m_err[d] = 1'b1;
        end else begin
            m_bcd[4*d +: 4] = v ? bcd : 4'd0;
            m_val[d] = v;
            m_err[d] = 1'b0;
        end
        changed = ({ob, ov, oe} != {m_bcd[4*d +: 4], m_val[d], m_err[d]});
    endtask

    initial begin
        logic ch;
        logic [3:0] sel;

        tbl[0]  = '{7'b1111110, 4'd0, 1'b1, 1'b0};
        tbl[1]  = '{7'b0110000, 4'd1, 1'b1, 1'b0};
        tbl[2]  = '{7'b1101101, 4'd2, 1'b1, 1'b0};
        tbl[3]  = '{7'b1111001, 4'd3, 1'b1, 1'b0};
        tbl[4]  = '{7'b0110011, 4'd4, 1'b1, 1'b0};
        tbl[5]  = '{7'b1011011, 4'd5, 1'b1, 1'b0};
        tbl[6]  = '{7'b1011111, 4'd6, 1'b1, 1'b0};
        tbl[7]  = '{7'b1110000, 4'd7, 1'b1, 1'b0};
        tbl[8]  = '{7'b1111111, 4'd8, 1'b1, 1'b0};
        tbl[9]  = '{7'b1111011, 4'd9, 1'b1, 1'b0};
        tbl[10] = '{7'b0001000, 4'd0, 1'b0, 1'b1};
        tbl[11] = '{7'b0000000, 4'd0, 1'b0, 1'b0};

        m_bcd = '0;
        m_val = '0;
        m_err = '0;
        bus.seg_in    = 7'b0;
        bus.dig_sel   = 4'b0;
        bus.sample_en = 1'b0;

        // T1: reset state, then commit a 3 on digit 0
        repeat (3) @(posedge clk);
        #1;
        check_state("reset", 1'b0, 1'b0);
        rst_n = 1'b1;
        send(7'b1111001, 4'b0001); check_state("t1 s1", 1'b0, 1'b0);
        send(7'b1111001, 4'b0001); check_state("t1 s2", 1'b0, 1'b0);
        send(7'b1111001, 4'b0001);
        mcommit(0, 4'd3, 1'b1, 1'b0, ch);
        check_state("t1 commit", ch, 1'b0);
        @(posedge clk); #1;
        chk("t1 upd pulse width", 32'(bus.upd), 32'd0);
        send(7'b1111001, 4'b0001); check_state("t1 s4 no recommit", 1'b0, 1'b0);

        // T2: digit 1, interrupted candidate then an 8
        send(7'b0110000, 4'b0010); check_state("t2 a1", 1'b0, 1'b0);
        send(7'b0110000, 4'b0010); check_state("t2 a2", 1'b0, 1'b0);
        send(7'b1111111, 4'b0010); check_state("t2 b1", 1'b0, 1'b0);
        send(7'b1111111, 4'b0010); check_state("t2 b2", 1'b0, 1'b0);
        send(7'b1111111, 4'b0010);
        mcommit(1, 4'd8, 1'b1, 1'b0, ch);
        check_state("t2 commit", ch, 1'b0);

        // T3: illegal pattern on digit 0 keeps bcd 3
        send(7'b1000001, 4'b0001); check_state("t3 s1", 1'b0, 1'b0);
        send(7'b1000001, 4'b0001); check_state("t3 s2", 1'b0, 1'b0);
        send(7'b1000001, 4'b0001);
        mcommit(0, 4'd0, 1'b0, 1'b1, ch);
        check_state("t3 commit", ch, 1'b0);
        chk("t3 bcd held", 32'(bus.bcd_out[3:0]), 32'd3);

        // T4: bad selects are dropped and do not advance the count
        send(7'b1111110, 4'b0001); check_state("t4 g1", 1'b0, 1'b0);
        send(7'b1111110, 4'b0001); check_state("t4 g2", 1'b0, 1'b0);
        send(7'b1111110, 4'b0011); check_state("t4 multihot", 1'b0, 1'b1);
        send(7'b1111110, 4'b0000); check_state("t4 zero sel", 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("t4 sel_err pulse width", 32'(bus.sel_err), 32'd0);
        send(7'b1111110, 4'b0001);
        mcommit(0, 4'd0, 1'b1, 1'b0, ch);
        check_state("t4 commit", ch, 1'b0);

        // T5: every table entry on every digit
        for (int d = 0; d < DIGITS; d++) begin
            sel = 4'(1 << d);
            for (int i = 0; i < 12; i++) begin
                send(tbl[i].seg, sel); check_state($sformatf("t5 d%0d v%0d s1", d, i), 1'b0, 1'b0);
                send(tbl[i].seg, sel); check_state($sformatf("t5 d%0d v%0d s2", d, i), 1'b0, 1'b0);
                send(tbl[i].seg, sel);
                mcommit(d, tbl[i].bcd, tbl[i].valid, tbl[i].err, ch);
                check_state($sformatf("t5 d%0d v%0d commit", d, i), ch, 1'b0);
            end
        end

        // T6: reset in the middle of a count, with a sample in flight
        send(7'b1101101, 4'b0100);
        send(7'b1101101, 4'b0100);
        send(7'b1101101, 4'b0100);
        mcommit(2, 4'd2, 1'b1, 1'b0, ch);
        check_state("t6 pre commit", ch, 1'b0);
        send(7'b1101101, 4'b1000); check_state("t6 c1", 1'b0, 1'b0);
        send(7'b1101101, 4'b1000); check_state("t6 c2", 1'b0, 1'b0);
        bus.seg_in    = 7'b1101101;
        bus.dig_sel   = 4'b1000;
        bus.sample_en = 1'b1;
        @(posedge clk); #1;
        bus.sample_en = 1'b0;
        bus.dig_sel   = 4'b0000;
        rst_n = 1'b0;
        #1;
        m_bcd = '0;
        m_val = '0;
        m_err = '0;
        check_state("t6 async reset", 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_state("t6 after release", 1'b0, 1'b0);
        send(7'b1101101, 4'b1000); check_state("t6 r1 no commit", 1'b0, 1'b0);
        send(7'b1101101, 4'b1000); check_state("t6 r2", 1'b0, 1'b0);
        send(7'b1101101, 4'b1000);
        mcommit(3, 4'd2, 1'b1, 1'b0, ch);
        check_state("t6 r3 commit", ch, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
